cbus_rr_arbiter: RTL and testbench

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

---
 rtl/cbus_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter that shares one downstream cbus among NUM_INPUTS requesters,
// holding the bus for a whole transaction and keeping per-requester grant/wait counters.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]          ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]          iresps,
  output cbus_req_t                            oreq,
  input  cbus_resp_t                           oresp,
  output logic [NUM_INPUTS-1:0]                grant,
  output logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] grant_cnt,
  output logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] wait_cnt
);
  localparam int              IDXW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                               r_state;
  logic [IDXW-1:0]                      r_ptr;
  logic [IDXW-1:0]                      r_index;
  logic [NUM_INPUTS-1:0]                r_grant;
  logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] r_grant_cnt;
  logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] r_wait_cnt;

  logic [NUM_INPUTS-1:0] w_valid;
  logic                  w_found;
  logic [IDXW-1:0]       w_sel;
  logic [NUM_INPUTS-1:0] w_sel_oh;
  int unsigned           w_cand;
  logic                  w_done;
  logic [IDXW-1:0]       w_next_ptr;

  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      w_valid[i] = ireqs[i].valid;
    end
  end

  // Scan from r_ptr upward, wrapping explicitly so non-power-of-two counts stay in range.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      w_cand = 32'(r_ptr) + k;
      if (w_cand >= NUM_INPUTS) begin
        w_cand = w_cand - NUM_INPUTS;
      end
      if (!w_found && w_valid[w_cand[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      w_sel_oh[i] = (w_sel == IDXW'(i));
    end
  end

  assign w_done     = (r_state == BUSY) && oresp.ready && oresp.last;
  assign w_next_ptr = (r_index == LAST_IDX) ? '0 : r_index + IDXW'(1);

  always_comb begin
    oreq = '0;
    if (r_state == BUSY) begin
      oreq = ireqs[r_index];
    end
  end

  always_comb begin
    iresps = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if ((r_state == BUSY) && (r_index == IDXW'(i))) begin
        iresps[i] = oresp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_index     <= '0;
      r_grant     <= '0;
      r_grant_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (w_valid[i] && !r_grant[i]) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + CNT_WIDTH'(1);
        end
      end
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= BUSY;
            r_index <= w_sel;
            r_grant <= w_sel_oh;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state              <= IDLE;
            r_grant              <= '0;
            r_ptr                <= w_next_ptr;
            r_grant_cnt[r_index] <= r_grant_cnt[r_index] + CNT_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_cnt = r_grant_cnt;
  assign wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: three instances (2, 3 and 1 requesters)
// exercised in turn with hand-computed expectations.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic                  rst_a, rst_b, rst_c;
  cbus_req_t  [1:0]      req_a;
  cbus_resp_t [1:0]      irsp_a;
  cbus_req_t             oreq_a;
  cbus_resp_t            resp_a;
  logic [1:0]            grant_a;
  logic [1:0][31:0]      gcnt_a, wcnt_a;

  cbus_req_t  [2:0]      req_b;
  cbus_resp_t [2:0]      irsp_b;
  cbus_req_t             oreq_b;
  cbus_resp_t            resp_b;
  logic [2:0]            grant_b;
  logic [2:0][7:0]       gcnt_b, wcnt_b;

  cbus_req_t  [0:0]      req_c;
  cbus_resp_t [0:0]      irsp_c;
  cbus_req_t             oreq_c;
  cbus_resp_t            resp_c;
  logic [0:0]            grant_c;
  logic [0:0][3:0]       gcnt_c, wcnt_c;

  cbus_rr_arbiter #(.NUM_INPUTS(2), .CNT_WIDTH(32)) u_dut_a (
    .clk(clk), .reset(rst_a), .ireqs(req_a), .iresps(irsp_a), .oreq(oreq_a),
    .oresp(resp_a), .grant(grant_a), .grant_cnt(gcnt_a), .wait_cnt(wcnt_a)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3), .CNT_WIDTH(8)) u_dut_b (
    .clk(clk), .reset(rst_b), .ireqs(req_b), .iresps(irsp_b), .oreq(oreq_b),
    .oresp(resp_b), .grant(grant_b), .grant_cnt(gcnt_b), .wait_cnt(wcnt_b)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(1), .CNT_WIDTH(4)) u_dut_c (
    .clk(clk), .reset(rst_c), .ireqs(req_c), .iresps(irsp_c), .oreq(oreq_c),
    .oresp(resp_c), .grant(grant_c), .grant_cnt(gcnt_c), .wait_cnt(wcnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic cbus_req_t mkreq(input logic v, input logic [15:0] a, input logic [31:0] d);
    cbus_req_t r;
    r.valid = v;
    r.write = 1'b1;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.rdata = d;
    return r;
  endfunction

  int         exp_idx_a [4] = '{0, 1, 0, 1};
  logic [2:0] exp_oh_b  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = '0; resp_a = '0;
    req_b = '0; resp_b = '0;
    req_c = '0; resp_c = '0;
    tick();
    tick();

    chk("rst_grant_a", grant_a, 0);
    chk("rst_gcnt_a",  gcnt_a,  0);
    chk("rst_wcnt_a",  wcnt_a,  0);
    chk("rst_oreq_a",  oreq_a,  0);
    chk("rst_iresp_a", irsp_a,  0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_gcnt_c",  gcnt_c,  0);

    // Two requesters, both valid, 4-beat transactions alternate 0,1,0,1.
    rst_a    = 1'b0;
    req_a[0] = mkreq(1'b1, 16'h0010, 32'hA0A0_0000);
    req_a[1] = mkreq(1'b1, 16'h0020, 32'hB0B0_0000);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_grant", grant_a, (exp_idx_a[t] == 0) ? 2'b01 : 2'b10);
      chk("rr_oreq",  oreq_a,  req_a[exp_idx_a[t]]);
      for (int b = 1; b <= 4; b++) begin
        resp_a = mkresp(1'b1, (b == 4), 32'h1000 + b);
        #1;
        chk("rr_iresp_own",   irsp_a[exp_idx_a[t]],     resp_a);
        chk("rr_iresp_other", irsp_a[1 - exp_idx_a[t]], 0);
        tick();
      end
      resp_a = '0;
      chk("rr_idle_gap", grant_a, 0);
    end
    chk("rr_gcnt0", gcnt_a[0], 2);
    chk("rr_gcnt1", gcnt_a[1], 2);

    req_a = '0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;

    // last without ready holds the bus; owner dropping valid still owns it.
    req_a[0] = mkreq(1'b1, 16'h0034, 32'h3434_0000);
    tick();
    chk("hold_grant_enter", grant_a, 2'b01);
    resp_a = mkresp(1'b0, 1'b1, 32'hDEAD_0000);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        req_a[0].valid = 1'b0;
        #1;
        chk("drop_oreq", oreq_a, mkreq(1'b0, 16'h0034, 32'h3434_0000));
      end
      tick();
      chk("hold_grant", grant_a,   2'b01);
      chk("hold_gcnt",  gcnt_a[0], 0);
    end
    resp_a = mkresp(1'b1, 1'b1, 32'hBEEF_0000);
    tick();
    chk("hold_release_grant", grant_a,   0);
    chk("hold_release_gcnt",  gcnt_a[0], 1);
    resp_a = '0;
    tick();
    chk("idle_no_valid", grant_a, 0);

    // Input 1 waits through arbitration plus a 5-cycle ownership by input 0.
    rst_a = 1'b1;
    tick();
    rst_a    = 1'b0;
    req_a[0] = mkreq(1'b1, 16'h0350, 32'h3500_0000);
    req_a[1] = mkreq(1'b1, 16'h0351, 32'h3510_0000);
    tick();
    chk("wait_grant", grant_a,   2'b01);
    chk("wait_w0_a",  wcnt_a[0], 1);
    chk("wait_w1_a",  wcnt_a[1], 1);
    for (int b = 1; b <= 5; b++) begin
      resp_a = mkresp(1'b1, (b == 5), 32'h3500 + b);
      #1;
      chk("wait_iresp1_zero", irsp_a[1], 0);
      chk("wait_frozen",      grant_a,   2'b01);
      tick();
    end
    resp_a = '0;
    chk("wait_idle",  grant_a,   0);
    chk("wait_w1_b",  wcnt_a[1], 6);
    chk("wait_w0_b",  wcnt_a[0], 1);

    // Reset mid-burst on input 1, coinciding with a last beat.
    tick();
    chk("mid_grant1", grant_a,   2'b10);
    chk("mid_w1",     wcnt_a[1], 7);
    resp_a = mkresp(1'b1, 1'b0, 32'h3600_0001);
    tick();
    tick();
    rst_a  = 1'b1;
    resp_a = mkresp(1'b1, 1'b1, 32'h3600_0003);
    tick();
    chk("mid_rst_grant", grant_a, 0);
    chk("mid_rst_oreq",  oreq_a,  0);
    chk("mid_rst_iresp", irsp_a,  0);
    chk("mid_rst_gcnt",  gcnt_a,  0);
    chk("mid_rst_wcnt",  wcnt_a,  0);
    tick();
    chk("mid_rst_hold_oreq",  oreq_a, 0);
    chk("mid_rst_hold_iresp", irsp_a, 0);
    rst_a  = 1'b0;
    resp_a = '0;
    tick();
    chk("post_rst_grant", grant_a,   2'b01);
    chk("post_rst_w1",    wcnt_a[1], 1);
    resp_a = mkresp(1'b1, 1'b1, 32'h3700_0000);
    tick();
    chk("post_rst_gcnt0", gcnt_a[0], 1);
    chk("post_rst_gcnt1", gcnt_a[1], 0);
    resp_a = '0;
    req_a  = '0;

    // Three requesters: lone input 2, then all valid to exercise the 2->0 wrap.
    rst_b    = 1'b0;
    req_b[2] = mkreq(1'b1, 16'h0332, 32'h3320_0000);
    tick();
    chk("n3_grant2", grant_b, 3'b100);
    chk("n3_oreq2",  oreq_b,  mkreq(1'b1, 16'h0332, 32'h3320_0000));
    resp_b = mkresp(1'b1, 1'b1, 32'h3321_0000);
    #1;
    chk("n3_iresp2", irsp_b[2], mkresp(1'b1, 1'b1, 32'h3321_0000));
    chk("n3_iresp0", irsp_b[0], 0);
    tick();
    resp_b = '0;
    chk("n3_idle",   grant_b,   0);
    chk("n3_gcnt2",  gcnt_b[2], 1);
    req_b[0] = mkreq(1'b1, 16'h0330, 32'h3300_0000);
    req_b[1] = mkreq(1'b1, 16'h0331, 32'h3310_0000);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("n3_rr_grant", grant_b, exp_oh_b[t]);
      resp_b = mkresp(1'b1, 1'b1, 32'h3390_0000);
      tick();
      resp_b = '0;
      chk("n3_rr_idle", grant_b, 0);
    end
    chk("n3_gcnt0_final", gcnt_b[0], 2);
    chk("n3_gcnt1_final", gcnt_b[1], 1);
    chk("n3_gcnt2_final", gcnt_b[2], 2);
    req_b = '0;

    // Single requester, 4-bit counters wrap after 16 transactions.
    rst_c    = 1'b0;
    req_c[0] = mkreq(1'b1, 16'h0370, 32'h3700_0000);
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("n1_grant", grant_c, 1'b1);
      resp_c = mkresp(1'b1, 1'b1, 32'h3700_0000 + n);
      tick();
      resp_c = '0;
      if (n == 15) begin
        chk("n1_gcnt_15", gcnt_c, 4'hF);
        chk("n1_wcnt_15", wcnt_c, 4'hF);
      end
    end
    chk("n1_gcnt_wrap", gcnt_c,  0);
    chk("n1_wcnt_wrap", wcnt_c,  0);
    chk("n1_idle",      grant_c, 0);
    req_c = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
